// File: rtl/muldiv_unit_if.sv
// Start/done handshake and result bus of the iterative multiply/divide unit.
// The requester drives the operation through the master modport; the unit
// answers with status, results and flags on the slave modport.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ResultLo;
   logic [WIDTH-1:0] ResultHi;
   logic [3:0]       Flags;
   logic             DivZero;

   modport master (
      output Start, Op, SrcA, SrcB,
      input  Busy, Done, ResultLo, ResultHi, Flags, DivZero
   );

   modport slave (
      input  Start, Op, SrcA, SrcB,
      output Busy, Done, ResultLo, ResultHi, Flags, DivZero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 integer multiply/divide unit.
// MUL/UMULL/SMULL use a shift-add engine, UDIV/SDIV a restoring shift-subtract
// engine. Signed ops run on magnitudes; the sign is restored in a single FIX
// cycle. Results and flags are registered and held until the next operation's
// FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_UMULL = 3'b001;
   localparam logic [2:0] OP_SMULL = 3'b010;
   localparam logic [2:0] OP_UDIV  = 3'b100;
   localparam logic [2:0] OP_SDIV  = 3'b101;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Only the five defined opcodes start the engine.
   function automatic logic op_legal(input logic [2:0] op);
      logic ok;
      case (op)
         OP_MUL, OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV: ok = 1'b1;
         default:                                      ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Magnitude of a two's-complement value when signed handling is enabled.
   // The most-negative value maps to itself, which is its correct unsigned
   // magnitude.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                input logic             en);
      logic [WIDTH-1:0] r;
      if (en && v[WIDTH-1]) begin
         r = -v;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t             state_r;
   state_t             state_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [2:0]         op_r;
   logic [WIDTH-1:0]   srca_r;      // multiplicand magnitude / dividend magnitude
   logic [WIDTH-1:0]   srcb_r;      // multiplier magnitude / divisor magnitude
   logic [2*WIDTH-1:0] acc_r;       // {hi, lo} product or {rem, quot}
   logic               neg_r;       // result sign for SMULL / quotient sign for SDIV
   logic               dsign_r;     // dividend sign for SDIV remainder

   logic [WIDTH-1:0]   res_lo_r;
   logic [WIDTH-1:0]   res_hi_r;
   logic [3:0]         flags_r;
   logic               divzero_r;
   logic               busy_r;
   logic               done_r;

   // Operand capture signals
   logic               signed_op_s;
   logic [WIDTH-1:0]   a_abs_s;
   logic [WIDTH-1:0]   b_abs_s;
   logic               start_ok_s;
   logic               start_bad_s;

   // Iteration step signals
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     rem_sh_s;
   logic [WIDTH:0]     diff_s;
   logic [2*WIDTH-1:0] step_s;

   // Fix-up signals
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   res_lo_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic               flag_n_s;
   logic               flag_z_s;
   logic               dz_s;

   assign start_ok_s  = bus.Start &&  op_legal(bus.Op);
   assign start_bad_s = bus.Start && !op_legal(bus.Op);

   // Magnitudes and result signs computed from the live inputs for capture.
   always_comb begin
      signed_op_s = (bus.Op == OP_SMULL) || (bus.Op == OP_SDIV);
      a_abs_s     = abs_val(bus.SrcA, signed_op_s);
      b_abs_s     = abs_val(bus.SrcB, signed_op_s);
   end

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, srca_r} : {1'b0, ZERO_W});
      rem_sh_s  = acc_r[2*WIDTH-1:WIDTH-1];
      diff_s    = rem_sh_s - {1'b0, srcb_r};
      if (op_r[2]) begin
         if (!diff_s[WIDTH]) begin
            step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end
   end

   // Sign restoration, divide-by-zero handling and flag generation for FIX.
   always_comb begin
      res_lo_s = ZERO_W;
      res_hi_s = ZERO_W;
      flag_n_s = 1'b0;
      flag_z_s = 1'b0;
      dz_s     = 1'b0;
      if (neg_r) begin
         prod_s = -acc_r;
      end else begin
         prod_s = acc_r;
      end
      case (op_r)
         OP_MUL: begin
            res_lo_s = acc_r[WIDTH-1:0];
            flag_n_s = res_lo_s[WIDTH-1];
            flag_z_s = (res_lo_s == ZERO_W);
         end
         OP_UMULL, OP_SMULL: begin
            if (op_r == OP_SMULL) begin
               {res_hi_s, res_lo_s} = prod_s;
            end else begin
               {res_hi_s, res_lo_s} = acc_r;
            end
            flag_n_s = res_hi_s[WIDTH-1];
            flag_z_s = ({res_hi_s, res_lo_s} == {2*WIDTH{1'b0}});
         end
         OP_UDIV, OP_SDIV: begin
            dz_s = (srcb_r == ZERO_W);
            if (dz_s) begin
               res_lo_s = ZERO_W;
            end else if (op_r == OP_SDIV && neg_r) begin
               res_lo_s = -acc_r[WIDTH-1:0];
            end else begin
               res_lo_s = acc_r[WIDTH-1:0];
            end
            if (op_r == OP_SDIV && dsign_r) begin
               res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            end else begin
               res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
            flag_n_s = res_lo_s[WIDTH-1];
            flag_z_s = (res_lo_s == ZERO_W);
         end
         default: begin
            res_lo_s = ZERO_W;
            res_hi_s = ZERO_W;
         end
      endcase
   end

   // Next-state logic of the IDLE/RUN/FIX/DONE sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_s = ST_RUN;
            end else if (start_bad_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FIX:  state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand capture in IDLE and one engine step per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r    <= 3'b000;
         srca_r  <= ZERO_W;
         srcb_r  <= ZERO_W;
         acc_r   <= {2*WIDTH{1'b0}};
         neg_r   <= 1'b0;
         dsign_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  op_r    <= bus.Op;
                  srca_r  <= a_abs_s;
                  srcb_r  <= b_abs_s;
                  neg_r   <= signed_op_s && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                  dsign_r <= (bus.Op == OP_SDIV) && bus.SrcA[WIDTH-1];
                  // Upper half cleared; lower half seeded with the operand
                  // that is consumed bit by bit (multiplier or dividend).
                  acc_r   <= {ZERO_W, (bus.Op[2] ? a_abs_s : b_abs_s)};
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r   <= cnt_r;
               end
            end
            ST_RUN: begin
               acc_r <= step_s;
               cnt_r <= cnt_r + CNT_ONE;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Result/flag registers: loaded in FIX, or zeroed for an illegal opcode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_lo_r  <= ZERO_W;
         res_hi_r  <= ZERO_W;
         flags_r   <= 4'b0000;
         divzero_r <= 1'b0;
      end else if (state_r == ST_FIX) begin
         res_lo_r  <= res_lo_s;
         res_hi_r  <= res_hi_s;
         flags_r   <= {flag_n_s, flag_z_s, 2'b00};
         divzero_r <= dz_s;
      end else if (state_r == ST_IDLE && start_bad_s) begin
         res_lo_r  <= ZERO_W;
         res_hi_r  <= ZERO_W;
         flags_r   <= 4'b0100;
         divzero_r <= 1'b0;
      end else begin
         res_lo_r  <= res_lo_r;
         res_hi_r  <= res_hi_r;
         flags_r   <= flags_r;
         divzero_r <= divzero_r;
      end
   end

   // Registered status outputs follow the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s == ST_RUN) || (state_s == ST_FIX);
         done_r <= (state_s == ST_DONE);
      end
   end

   assign bus.Busy     = busy_r;
   assign bus.Done     = done_r;
   assign bus.ResultLo = res_lo_r;
   assign bus.ResultHi = res_hi_r;
   assign bus.Flags    = flags_r;
   assign bus.DivZero  = divzero_r;
endmodule
